// File: rtl/fetch_pc_gen.sv
// Fetch-stage program-counter generator: issues the fetch PC over a valid/ready
// request and handles trap, mret and branch redirects in fixed priority.
module fetch_pc_gen #(
  parameter int unsigned XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter int unsigned INCR         = 4,
  parameter int unsigned IALIGN       = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             trap_taken,
  input  logic [XLEN-1:0]  trap_vector,
  input  logic             mret_taken,
  input  logic [XLEN-1:0]  mepc,
  input  logic             imem_req_ready,
  output logic             imem_req_valid,
  output logic [XLEN-1:0]  pc,
  output logic             redirect_pending,
  output logic             fetch_misaligned,
  output logic [XLEN-1:0]  fetch_fault_addr,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_PEND, S_FAULT} state_t;

  state_t          state;
  logic [XLEN-1:0] pend_tgt;

  logic            in_flow_c;
  logic            fire_c;
  logic            hold_branch_c;
  logic            take_redirect_c;
  logic [XLEN-1:0] redirect_tgt_c;
  logic [XLEN-1:0] trap_tgt_c;

  // A live branch outranks the latched one; PEND with no stall replays the latch.
  assign in_flow_c       = (state == S_RUN) || (state == S_PEND);
  assign hold_branch_c   = in_flow_c && branch_taken && stall;
  assign take_redirect_c = in_flow_c && !stall && (branch_taken || (state == S_PEND));
  assign redirect_tgt_c  = branch_taken ? branch_target : pend_tgt;
  assign trap_tgt_c      = trap_vector & ~ALIGN_MASK;
  assign fire_c          = (state == S_RUN) && imem_req_ready && !stall;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return |(addr & ALIGN_MASK);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_BOOT;
      pc               <= RESET_VECTOR;
      pend_tgt         <= '0;
      fetch_fault_addr <= '0;
      fetch_count      <= '0;
    end else if (trap_taken) begin
      pc       <= trap_tgt_c;
      pend_tgt <= '0;
      state    <= S_RUN;
    end else if (mret_taken) begin
      pend_tgt <= '0;
      if (is_misaligned(mepc)) begin
        fetch_fault_addr <= mepc;
        state            <= S_FAULT;
      end else begin
        pc    <= mepc;
        state <= S_RUN;
      end
    end else if (hold_branch_c) begin
      pend_tgt <= branch_target;
      state    <= S_PEND;
    end else if (take_redirect_c) begin
      if (is_misaligned(redirect_tgt_c)) begin
        fetch_fault_addr <= redirect_tgt_c;
        state            <= S_FAULT;
      end else begin
        pc    <= redirect_tgt_c;
        state <= S_RUN;
      end
    end else if (state == S_BOOT) begin
      state <= S_RUN;
    end else if (fire_c) begin
      pc          <= pc + XLEN'(INCR);
      fetch_count <= fetch_count + CNT_W'(1);
    end
  end

  // Status outputs are pure decodes of the state register.
  assign imem_req_valid   = (state == S_RUN);
  assign redirect_pending = (state == S_PEND);
  assign fetch_misaligned = (state == S_FAULT);

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed scenarios plus random traffic
// compared every cycle against a behavioural model.
module tb_fetch_pc_gen;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;
  localparam logic [31:0] RV    = 32'h0000_0100;

  localparam int M_BOOT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PEND  = 2;
  localparam int M_FAULT = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             stall, branch_taken, trap_taken, mret_taken, imem_req_ready;
  logic [XLEN-1:0]  branch_target, trap_vector, mepc;
  logic             imem_req_valid, redirect_pending, fetch_misaligned;
  logic [XLEN-1:0]  pc, fetch_fault_addr;
  logic [CNT_W-1:0] fetch_count;

  fetch_pc_gen #(
    .XLEN(XLEN), .RESET_VECTOR(RV), .INCR(4), .IALIGN(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .trap_taken(trap_taken), .trap_vector(trap_vector),
    .mret_taken(mret_taken), .mepc(mepc),
    .imem_req_ready(imem_req_ready), .imem_req_valid(imem_req_valid),
    .pc(pc), .redirect_pending(redirect_pending),
    .fetch_misaligned(fetch_misaligned), .fetch_fault_addr(fetch_fault_addr),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state
  int               m_mode;
  logic [31:0]      m_pc, m_pend, m_fa;
  logic [CNT_W-1:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_BOOT;
    m_pc   = RV;
    m_pend = 32'h0;
    m_fa   = 32'h0;
    m_cnt  = '0;
  endtask

  task automatic model_redirect(input logic [31:0] t);
    if ((t % 4) != 0) begin
      m_fa   = t;
      m_mode = M_FAULT;
    end else begin
      m_pc   = t;
      m_mode = M_RUN;
    end
  endtask

  task automatic model_step();
    if (trap_taken) begin
      m_pc   = {trap_vector[31:2], 2'b00};
      m_mode = M_RUN;
    end else if (mret_taken) begin
      model_redirect(mepc);
    end else if ((m_mode == M_RUN || m_mode == M_PEND) && branch_taken) begin
      if (stall) begin
        m_pend = branch_target;
        m_mode = M_PEND;
      end else begin
        model_redirect(branch_target);
      end
    end else if (m_mode == M_PEND && !stall) begin
      model_redirect(m_pend);
    end else if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN && imem_req_ready && !stall) begin
      m_pc  = m_pc + 32'd4;
      m_cnt = m_cnt + 1'b1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic idle();
    stall = 0; branch_taken = 0; branch_target = '0;
    trap_taken = 0; trap_vector = '0; mret_taken = 0; mepc = '0;
    imem_req_ready = 1;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  task automatic chk_reset_vals();
    chk("rst_pc", pc, RV);
    chk("rst_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_pending", 32'(redirect_pending), 32'h0);
    chk("rst_misaligned", 32'(fetch_misaligned), 32'h0);
    chk("rst_fault_addr", fetch_fault_addr, 32'h0);
    chk("rst_count", 32'(fetch_count), 32'h0);
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_valid", 32'(imem_req_valid), 32'(m_mode == M_RUN));
      chk("m_pending", 32'(redirect_pending), 32'(m_mode == M_PEND));
      chk("m_misaligned", 32'(fetch_misaligned), 32'(m_mode == M_FAULT));
      chk("m_pc", pc, m_pc);
      chk("m_fault_addr", fetch_fault_addr, m_fa);
      chk("m_count", 32'(fetch_count), 32'(m_cnt));
    end
  end

  initial begin
    logic [CNT_W-1:0] c0;
    int guard;
    idle();
    model_reset();
    #1 rst = 1'b1;
    #1 chk_reset_vals();
    cmp_en = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;

    // Boot then sequential fetch from the reset vector
    chk("boot_valid", 32'(imem_req_valid), 32'h0);
    cycle();
    chk("seq0_pc", pc, 32'h100);
    chk("seq0_valid", 32'(imem_req_valid), 32'h1);
    cycle(); chk("seq1_pc", pc, 32'h104);
    cycle(); chk("seq2_pc", pc, 32'h108);
    cycle(); chk("seq3_pc", pc, 32'h10C);
    chk("seq3_count", 32'(fetch_count), 32'd3);

    // Ready low holds pc and count
    branch_taken = 1; branch_target = 32'h8; imem_req_ready = 0;
    cycle(); chk("br8_pc", pc, 32'h8);
    c0 = fetch_count;
    branch_taken = 0;
    cycle(); cycle();
    chk("rdylo_pc", pc, 32'h8);
    chk("rdylo_count", 32'(fetch_count), 32'(c0));
    imem_req_ready = 1;
    cycle(); chk("rdyhi_pc", pc, 32'hC);
    chk("rdyhi_count", 32'(fetch_count), 32'(c0 + 1'b1));

    // Branch under stall, overwritten, then released
    stall = 1; branch_taken = 1; branch_target = 32'h40;
    cycle(); chk("pend_flag", 32'(redirect_pending), 32'h1);
    chk("pend_valid", 32'(imem_req_valid), 32'h0);
    branch_target = 32'h80;
    cycle();
    branch_taken = 0;
    cycle(); chk("pend_hold_pc", pc, 32'hC);
    stall = 0;
    cycle(); chk("pend_apply_pc", pc, 32'h80);
    chk("pend_clear", 32'(redirect_pending), 32'h0);

    // Trap beats mret and branch, ignoring stall
    stall = 1; branch_taken = 1; branch_target = 32'h40;
    cycle();
    trap_taken = 1; trap_vector = 32'h203; mret_taken = 1; mepc = 32'h500;
    branch_target = 32'h600;
    cycle(); chk("trap_pc", pc, 32'h200);
    chk("trap_pend", 32'(redirect_pending), 32'h0);
    idle();

    // Misaligned branch parks in FAULT until a trap
    branch_taken = 1; branch_target = 32'h42;
    cycle(); chk("mis_flag", 32'(fetch_misaligned), 32'h1);
    chk("mis_addr", fetch_fault_addr, 32'h42);
    chk("mis_valid", 32'(imem_req_valid), 32'h0);
    branch_target = 32'h80;
    cycle(); chk("mis_hold_pc", pc, 32'h200);
    chk("mis_hold_flag", 32'(fetch_misaligned), 32'h1);
    branch_taken = 0; trap_taken = 1; trap_vector = 32'h10;
    cycle(); chk("mis_exit_pc", pc, 32'h10);
    chk("mis_exit_valid", 32'(imem_req_valid), 32'h1);
    idle();

    // mret with misaligned then aligned mepc
    mret_taken = 1; mepc = 32'h6;
    cycle(); chk("mret_mis_addr", fetch_fault_addr, 32'h6);
    chk("mret_mis_flag", 32'(fetch_misaligned), 32'h1);
    mepc = 32'h300;
    cycle(); chk("mret_pc", pc, 32'h300);
    idle();

    // PC wrap at the top of the address space
    branch_taken = 1; branch_target = 32'hFFFF_FFFC; imem_req_ready = 0;
    cycle();
    idle();
    cycle(); chk("pc_wrap", pc, 32'h0);

    // Counter wrap
    guard = 0;
    while (m_cnt != {CNT_W{1'b1}} && guard < 300) begin
      cycle();
      guard++;
    end
    chk("cnt_max", 32'(fetch_count), 32'hFF);
    cycle(); chk("cnt_wrap", 32'(fetch_count), 32'h0);

    // Random traffic with a mid-run asynchronous reset
    for (int i = 0; i < 1500; i++) begin
      stall          = ($urandom_range(0, 9) < 3);
      branch_taken   = ($urandom_range(0, 9) < 2);
      branch_target  = rnd_addr();
      trap_taken     = ($urandom_range(0, 99) < 3);
      trap_vector    = $urandom;
      mret_taken     = ($urandom_range(0, 99) < 3);
      mepc           = rnd_addr();
      imem_req_ready = ($urandom_range(0, 9) < 7);
      if (i == 700) begin
        #2 rst = 1'b1;
        model_reset();
        #1 chk_reset_vals();
        cycle();
        rst = 1'b0;
      end
      cycle();
    end

    idle();
    cycle();
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Parametrised program-counter generator for the fetch stage of the RV32IM core. It holds the fetch PC and issues it to instruction memory through a valid/ready request. It supports redirects from the trap unit (trap entry), CSR unit (mret) and EX stage (branch/jump) in fixed priority. A branch that arrives under stall is held as a pending redirect, a misaligned redirect target parks the block in a fault state, and accepted fetches are counted.

## Interface
Parameters:
- XLEN, 32, PC/address width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded at reset.
- INCR, 4, sequential PC step in bytes.
- IALIGN, 4, required target alignment in bytes; legal values 2 or 4.
- CNT_W, 32, width of the fetch counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  pipeline hold from the hazard unit.
- branch_taken  in  1  EX-stage redirect request.
- branch_target  in  XLEN  EX-stage redirect address.
- trap_taken  in  1  trap entry request.
- trap_vector  in  XLEN  trap handler address.
- mret_taken  in  1  return-from-trap request.
- mepc  in  XLEN  return address.
- imem_req_ready  in  1  instruction memory accepts a request.
- imem_req_valid  out  1  fetch request valid.
- pc  out  XLEN  current fetch address (imem request address).
- redirect_pending  out  1  a branch is held waiting for the stall to clear.
- fetch_misaligned  out  1  fault: the redirect target violated IALIGN.
- fetch_fault_addr  out  XLEN  offending target; valid while fetch_misaligned = 1.
- fetch_count  out  CNT_W  number of accepted fetches; wraps.

## Operation
The block has four states: BOOT, RUN, PEND and FAULT.

Definitions:
- fire = imem_req_valid & imem_req_ready & !stall.
- misaligned(x) = (x mod IALIGN) != 0.
- Trap target = trap_vector with its low log2(IALIGN) bits forced to 0. It is never misaligned.

Outputs by state:
- imem_req_valid = 1 only in RUN.
- redirect_pending = 1 only in PEND.
- fetch_misaligned = 1 only in FAULT.

Update priority, evaluated every cycle in every state, highest first:
1. trap_taken: pc <= trap target; clear pending; next state RUN. Ignores stall and ready.
2. mret_taken: if misaligned(mepc), set fetch_fault_addr <= mepc and go to FAULT. Otherwise pc <= mepc and go to RUN. Ignores stall and ready.
3. branch_taken, only in RUN or PEND:
   - stall = 1: latch branch_target into the pending register and go to PEND. In PEND, the newest branch overwrites the latched one.
   - stall = 0: apply the target directly. Misaligned target -> FAULT with fetch_fault_addr <= target. Aligned target -> pc <= target, state RUN.
4. PEND with stall = 0: apply the pending target using the same misalignment rule, then go to RUN or FAULT.
5. RUN with fire: pc <= pc + INCR, modulo 2^XLEN; fetch_count <= fetch_count + 1, wrapping.
6. Otherwise everything holds.

Further rules:
- BOOT lasts exactly one cycle after reset release, then goes to RUN. Rules 1 and 2 apply in BOOT.
- FAULT is left only by trap_taken or mret_taken. pc holds in FAULT.
- A redirect from rule 3 in RUN does not count as a fetch, even if ready = 1 in that cycle.
- pc may change while imem_req_valid = 1 and ready = 0. Memory must sample pc only on a handshake.

## Timing
- Reset values: pc = RESET_VECTOR, state BOOT, imem_req_valid = 0, redirect_pending = 0, fetch_misaligned = 0, fetch_fault_addr = 0, fetch_count = 0.
- All outputs are registered or decoded from the state register. There is no combinational path from any input to any output.
- Redirect latency is 1 cycle: a request sampled at edge N shows the new pc after edge N.
- A branch held in PEND reaches pc on the edge after the first cycle with stall = 0.
- Reset asserted mid-operation returns every output to its reset value immediately, regardless of clk.

## Test plan
- Reset release, ready = 1, stall = 0, RESET_VECTOR = 0x100 -> imem_req_valid = 0 for 1 cycle, then pc = 0x100, 0x104, 0x108; fetch_count reaches 3 after 3 fires.
- Ready low for 2 cycles at pc = 0x8 -> pc holds 0x8 and fetch_count is unchanged; both resume on the first handshake.
- stall = 1 with branch_taken to 0x40, then branch to 0x80 one cycle later, stall released after 3 cycles -> redirect_pending = 1 and imem_req_valid = 0 during the stall, then pc = 0x80.
- trap_taken (vector 0x203), mret_taken and branch_taken in the same cycle with stall = 1 -> pc = 0x200 and redirect_pending = 0.
- branch_taken to 0x42 with IALIGN = 4 -> fetch_misaligned = 1, fetch_fault_addr = 0x42, imem_req_valid = 0 until trap_taken to 0x10 gives pc = 0x10 in RUN.
- pc = 0xFFFF_FFFC with a fire -> pc wraps to 0x0. fetch_count preloaded by 2^CNT_W - 1 fires -> wraps to 0.
